// File: rtl/uart_bram_loopback_ctrl.sv
// Loopback sequencer: collects UART RX bytes into a byte BRAM until a terminator
// arrives or the buffer fills, then replays them in order through the UART TX.
module uart_bram_loopback_ctrl #(
   parameter int unsigned AddrWidth  = 10,
   parameter logic [7:0]  Terminator = 8'h0D
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [7:0]           RxByte,
   input  logic                 RxValid,
   output logic                 BramEn,
   output logic                 BramWe,
   output logic [AddrWidth-1:0] BramAddr,
   output logic [7:0]           BramDin,
   input  logic [7:0]           BramDout,
   output logic                 TxStart,
   output logic [7:0]           TxByte,
   input  logic                 TxDone,
   output logic [AddrWidth:0]   Count,
   output logic                 Overflow,
   output logic                 Busy
);

   typedef enum logic [2:0] {
      COLLECT,
      RD_REQ,
      RD_WAIT,
      SEND,
      WAIT_TX
   } state_t;

   localparam logic [AddrWidth:0] Depth = {1'b1, {AddrWidth{1'b0}}};

   state_t               state, state_next;
   logic                 rx_valid_d;
   logic                 rise;
   logic                 last_byte;
   logic [AddrWidth:0]   count_inc;
   logic [AddrWidth-1:0] wr_ptr, rd_ptr, rd_ptr_next;

   always_comb begin
      rise        = RxValid & ~rx_valid_d;
      count_inc   = Count + 1'b1;
      last_byte   = ({1'b0, rd_ptr} == (Count - 1'b1));
      state_next  = state;
      rd_ptr_next = rd_ptr;
      case (state)
         // BramWe high in COLLECT marks the write cycle of the byte just captured
         COLLECT: begin
            if (BramWe && ((BramDin == Terminator) || (count_inc == Depth))) begin
               state_next  = RD_REQ;
               rd_ptr_next = '0;
            end
         end
         RD_REQ:  state_next = RD_WAIT;
         RD_WAIT: state_next = SEND;
         SEND:    state_next = WAIT_TX;
         WAIT_TX: begin
            if (TxDone) begin
               if (last_byte) begin
                  state_next  = COLLECT;
                  rd_ptr_next = '0;
               end else begin
                  state_next  = RD_REQ;
                  rd_ptr_next = rd_ptr + 1'b1;
               end
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) state <= COLLECT;
      else     state <= state_next;
   end

   // All outputs are registered; next-cycle values derive from state_next.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_valid_d <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         BramEn     <= 1'b0;
         BramWe     <= 1'b0;
         BramAddr   <= '0;
         BramDin    <= '0;
         TxStart    <= 1'b0;
         TxByte     <= '0;
         Count      <= '0;
         Overflow   <= 1'b0;
         Busy       <= 1'b0;
      end else begin
         rx_valid_d <= RxValid;
         rd_ptr     <= rd_ptr_next;
         BramEn     <= 1'b0;
         BramWe     <= 1'b0;
         TxStart    <= 1'b0;
         Busy       <= (state_next != COLLECT);

         if (rise) begin
            if (state == COLLECT) begin
               BramEn   <= 1'b1;
               BramWe   <= 1'b1;
               BramAddr <= wr_ptr;
               BramDin  <= RxByte;
            end else begin
               Overflow <= 1'b1;
            end
         end

         if ((state == COLLECT) && BramWe) begin
            Count  <= count_inc;
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (state_next == RD_REQ) begin
            BramEn   <= 1'b1;
            BramAddr <= rd_ptr_next;
         end

         if (state == RD_WAIT) TxByte <= BramDout;
         if (state_next == SEND) TxStart <= 1'b1;

         if ((state == WAIT_TX) && TxDone && last_byte) begin
            Count  <= '0;
            wr_ptr <= '0;
         end
      end
   end

endmodule
